// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave shifter: FSM encoding, SPI mode
// constants ({CPOL,CPHA}) and legal parameter limits.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned SYNC_MIN  = 2;
  localparam int unsigned SYNC_MAX  = 4;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall
// pulses taken against one further registered copy of the synchronised level.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus the delayed copy used for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave shift engine: oversamples SCK/SS/MOSI on the system clock,
// assembles received words, and serialises a buffered transmit word on MISO.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             SCK,
  input  logic             SS,
  input  logic             Data_In,
  output logic             Data_Out,
  input  logic [WIDTH-1:0] Tx_Word,
  input  logic             Tx_Load,
  output logic             Tx_Ready,
  output logic [WIDTH-1:0] Rx_Word,
  output logic             SSPIF,
  output logic             Rx_Valid,
  input  logic             Rx_Ack,
  output logic             Overrun,
  output logic             Busy
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_params
    $error("spi_slave_shifter: WIDTH or SYNC_STAGES out of range");
  end

  localparam int unsigned          CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(WIDTH - 1);
  localparam logic [1:0]           MODE  = {CPOL, CPHA};
  // Leading edge is a falling SCK edge when the idle level is high
  localparam bit LEAD_IS_FALL    = (MODE == MODE2) || (MODE == MODE3);
  localparam bit SAMPLE_ON_TRAIL = (MODE == MODE1) || (MODE == MODE3);

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic sck_s, sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic din_s, din_rise, din_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sck (
    .clk_i(Clk), .rst_i(Rst), .d_i(SCK),
    .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk_i(Clk), .rst_i(Rst), .d_i(SS),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk_i(Clk), .rst_i(Rst), .d_i(Data_In),
    .q_o(din_s), .rise_o(din_rise), .fall_o(din_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_s, ss_s, din_rise, din_fall};

  // ---------------------------------------------------------------------
  // Edge classification
  // ---------------------------------------------------------------------
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = LEAD_IS_FALL    ? sck_fall   : sck_rise;
  assign trail_edge  = LEAD_IS_FALL    ? sck_rise   : sck_fall;
  assign sample_edge = SAMPLE_ON_TRAIL ? trail_edge : lead_edge;
  assign shift_edge  = SAMPLE_ON_TRAIL ? lead_edge  : trail_edge;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  spi_state_e state_q, state_d;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state follows the synchronised slave select
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (ss_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (ss_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_word_q, rx_word_d;
  logic             sspif_q, sspif_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic             tx_ready_q, tx_ready_d;
  logic             data_out_q, data_out_d;

  logic             in_word, ss_abort, do_sample, do_shift;
  logic             word_start, shift_bit;
  logic [WIDTH-1:0] rx_next, tx_next, tx_src;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign ss_abort  = (state_q == ST_ACTIVE) && ss_rise;
  assign in_word   = (state_q == ST_ACTIVE) && !ss_rise;
  assign do_sample = in_word && sample_edge;
  assign do_shift  = in_word && shift_edge;
  // A shift edge seen with the counter at zero begins a word: in CPHA=1
  // that is the first leading edge, in both modes it is also the edge
  // after bit WIDTH-1. CPHA=0 additionally starts on select assertion.
  assign word_start = (!SAMPLE_ON_TRAIL && (state_q == ST_IDLE) && ss_fall) ||
                      (do_shift && (cnt_q == '0));
  assign shift_bit  = do_shift && (cnt_q != '0);

  assign rx_next = MSB_FIRST ? {rx_sr_q[WIDTH-2:0], din_s} : {din_s, rx_sr_q[WIDTH-1:1]};
  assign tx_next = MSB_FIRST ? {tx_sr_q[WIDTH-2:0], 1'b0}  : {1'b0, tx_sr_q[WIDTH-1:1]};
  assign tx_src  = tx_ready_q ? '0 : tx_buf_q;

  // Receive assembly, status flags and transmit buffering
  always_comb begin
    cnt_d      = cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_word_d  = rx_word_q;
    sspif_d    = 1'b0;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    tx_sr_d    = tx_sr_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    data_out_d = data_out_q;

    if (Rx_Ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if (ss_abort) begin
      cnt_d      = '0;
      rx_sr_d    = '0;
      tx_sr_d    = '0;
      data_out_d = 1'b0;
    end else begin
      if (do_sample) begin
        rx_sr_d = rx_next;
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          rx_word_d  = rx_next;
          sspif_d    = 1'b1;
          rx_valid_d = 1'b1;
          // An acknowledge in the same cycle retires the old word instead
          if (rx_valid_q && !Rx_Ack) overrun_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      if (word_start) begin
        tx_sr_d    = tx_src;
        data_out_d = lead_bit(tx_src);
        tx_ready_d = 1'b1;
      end else if (shift_bit) begin
        tx_sr_d    = tx_next;
        data_out_d = lead_bit(tx_next);
      end
    end

    if (Tx_Load && tx_ready_q && !word_start) begin
      tx_buf_d   = Tx_Word;
      tx_ready_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      rx_word_q  <= '0;
      sspif_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      tx_sr_q    <= '0;
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
      data_out_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_word_q  <= rx_word_d;
      sspif_q    <= sspif_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      tx_sr_q    <= tx_sr_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      data_out_q <= data_out_d;
    end
  end

  assign Data_Out = data_out_q;
  assign Tx_Ready = tx_ready_q;
  assign Rx_Word  = rx_word_q;
  assign SSPIF    = sspif_q;
  assign Rx_Valid = rx_valid_q;
  assign Overrun  = overrun_q;
  assign Busy     = (state_q == ST_ACTIVE) && (cnt_q != '0);

endmodule
